// File: rtl/bram_copy_ctrl.sv
// Word-copy sequencer for a single-port BRAM: alternates read/write cycles to move
// LEN words from SRC to DST, and hands the BRAM to a host port while idle.
module bram_copy_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_din,
    output logic                  o_host_gnt,
    output logic [DATA_WIDTH-1:0] o_host_dout,
    output logic                  o_bram_we,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_din,
    input  logic [DATA_WIDTH-1:0] i_bram_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO = LEN_WIDTH'(0);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_sp;
    logic [ADDR_WIDTH-1:0] r_dp;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_host_gnt;
    logic                  w_bram_we;
    logic [ADDR_WIDTH-1:0] w_bram_addr;
    logic [DATA_WIDTH-1:0] w_bram_din;

    // Copy sequencer: pointers, word counter and busy/done flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_sp    <= '0;
            r_dp    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_len != LEN_ZERO) begin
                            r_state <= S_RD;
                            r_sp    <= i_src_addr;
                            r_dp    <= i_dst_addr;
                            r_cnt   <= i_len;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RD: begin
                    r_sp    <= r_sp + ADDR_ONE;
                    r_state <= S_WR;
                end
                S_WR: begin
                    r_dp  <= r_dp + ADDR_ONE;
                    r_cnt <= r_cnt - LEN_ONE;
                    if (r_cnt == LEN_ONE) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_RD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // BRAM port mux; a reset landing on a write cycle suppresses that write.
    always_comb begin
        w_host_gnt  = (r_state == S_IDLE) & i_host_req & ~i_start;
        w_bram_we   = 1'b0;
        w_bram_addr = i_host_addr;
        w_bram_din  = i_host_din;
        case (r_state)
            S_RD: begin
                w_bram_addr = r_sp;
            end
            S_WR: begin
                w_bram_we   = ~i_rst;
                w_bram_addr = r_dp;
                w_bram_din  = i_bram_dout;
            end
            default: begin
                w_bram_we   = w_host_gnt & i_host_we;
            end
        endcase
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_host_gnt  = w_host_gnt;
    assign o_host_dout = i_bram_dout;
    assign o_bram_we   = w_bram_we;
    assign o_bram_addr = w_bram_addr;
    assign o_bram_din  = w_bram_din;

endmodule
